// File: rtl/uart_tx_block.sv
// UART transmitter: one-entry holding buffer feeding an 8N1-style serializer
// with a runtime data width (5..8) and bit period, both latched per frame.
module uart_tx_block #(
  parameter int MIN_BIT_PERIOD = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        serial_out,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [13:0] MIN_PER = 14'(MIN_BIT_PERIOD);

  state_t      state;
  logic        buf_full;
  logic [7:0]  buf_data;
  logic [7:0]  shift;
  logic [3:0]  bit_cnt;
  logic [3:0]  lsize;
  logic [13:0] lper;
  logic [13:0] per_cnt;

  logic [3:0]  eff_size;
  logic [13:0] eff_per;
  logic        accept;
  logic        bit_end;
  logic        load;

  assign eff_size = (data_size >= 4'd5 && data_size <= 4'd8) ? data_size : 4'd8;
  assign eff_per  = (bit_period < MIN_PER) ? MIN_PER : bit_period;
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = (per_cnt == lper);
  // Buffer drains whenever the FSM begins a frame, from IDLE or straight out of STOP.
  assign load     = buf_full && ((state == IDLE) || (state == STOP && bit_end));

  // accept and load can never coincide: tx_ready high implies buf_full low.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (accept) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end else if (load) begin
        buf_full <= 1'b0;
      end
      tx_ready <= accept ? 1'b0 : !buf_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      lsize      <= '0;
      lper       <= '0;
      per_cnt    <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == STOP) && (per_cnt == lper - 14'd1);
      if (load) begin
        state      <= START;
        shift      <= buf_data;
        lsize      <= eff_size;
        lper       <= eff_per;
        bit_cnt    <= '0;
        per_cnt    <= 14'd1;
        serial_out <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          IDLE: per_cnt <= '0;
          START: begin
            if (bit_end) begin
              state      <= DATA;
              per_cnt    <= 14'd1;
              serial_out <= shift[0];
            end else begin
              per_cnt <= per_cnt + 14'd1;
            end
          end
          DATA: begin
            if (bit_end) begin
              per_cnt <= 14'd1;
              if (bit_cnt == lsize - 4'd1) begin
                state      <= STOP;
                serial_out <= 1'b1;
              end else begin
                shift      <= shift >> 1;
                serial_out <= shift[1];
                bit_cnt    <= bit_cnt + 4'd1;
              end
            end else begin
              per_cnt <= per_cnt + 14'd1;
            end
          end
          STOP: begin
            if (bit_end) begin
              state   <= IDLE;
              per_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              per_cnt <= per_cnt + 14'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// Directed bench for uart_tx_block: per-cycle line/busy/frame_done checks
// against a bit-level frame model for single, narrow, clamped, back-to-back and reset-abort cases.
module tb_uart_tx_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        serial_out;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_block #(.MIN_BIT_PERIOD(10)) dut (
    .clk(clk), .rst(rst), .data_size(data_size), .bit_period(bit_period),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .serial_out(serial_out), .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Waits (bounded) for tx_ready, then presents one byte for a single accept edge.
  task automatic send(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!tx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) chk("send_timeout", 0, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // Expected line level for frame slot i: start, n data bits LSB first, stop.
  function automatic logic level(input int i, input logic [7:0] d, input int n);
    if (i == 0) return 1'b0;
    if (i <= n) return d[i-1];
    return 1'b1;
  endfunction

  // Checks N=(n+2)*per cycles starting at the first start-bit cycle.
  task automatic check_frame(input logic [7:0] d, input int n, input int per, input bit chk_rdy);
    int total = (n + 2) * per;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      chk("line", serial_out, level((c - 1) / per, d, n));
      chk("busy", busy, 1);
      chk("frame_done", frame_done, (c == total) ? 1 : 0);
      if (chk_rdy) chk("ready_in_frame", tx_ready, (c == 1) ? 0 : 1);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_line"}, serial_out, 1);
    chk({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    rst = 1'b1; data_size = 4'd8; bit_period = 14'd10; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", serial_out, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;

    // Single 8-bit frame 0xA5: line 0,1,0,1,0,0,1,0,1,1 at 10 cycles each.
    send(8'hA5);
    @(negedge clk);
    chk("pre_start_line", serial_out, 1);
    check_frame(8'hA5, 8, 10, 1'b1);
    check_idle("a5_after");

    // 5-bit frame; config changes mid-frame must not affect it.
    data_size = 4'd5;
    send(8'hFF);
    @(negedge clk);
    fork
      check_frame(8'hFF, 5, 10, 1'b1);
      begin
        repeat (3) @(negedge clk);
        data_size  = 4'd8;
        bit_period = 14'd20;
      end
    join
    check_idle("five_after");

    // Clamping: period 3 -> 10, size 12 -> 8.
    bit_period = 14'd3; data_size = 4'd12;
    send(8'h3C);
    @(negedge clk);
    check_frame(8'h3C, 8, 10, 1'b1);
    check_idle("clamp_after");

    // Back-to-back: second byte queued mid-frame, no idle gap.
    bit_period = 14'd10; data_size = 4'd8;
    send(8'h55);
    @(negedge clk);
    fork
      check_frame(8'h55, 8, 10, 1'b0);
      begin
        repeat (20) @(negedge clk);
        send(8'h0F);
        @(negedge clk);
        chk("b2b_ready_low", tx_ready, 0);
        repeat (60) @(negedge clk);
        chk("b2b_ready_still_low", tx_ready, 0);
      end
    join
    check_frame(8'h0F, 8, 10, 1'b1);
    check_idle("b2b_after");

    // Reset abort mid-DATA with a byte buffered.
    send(8'h00);
    @(negedge clk);
    repeat (35) @(negedge clk);
    send(8'h3C);
    @(negedge clk);
    chk("abort_buffered", tx_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_line", serial_out, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", tx_ready, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("abort_no_resend", serial_out, 1);
    end
    send(8'hC3);
    @(negedge clk);
    check_frame(8'hC3, 8, 10, 1'b1);
    check_idle("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
